// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - 3x3 convolution scan controller and MAC datapath
// Issues window addresses, aligns returned rows with a tag pipeline, emits clamped pixels.
module conv3x3_engine #(
   parameter int IMG_W = 32,
   parameter int SHIFT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [71:0] kernel,
   input  logic [7:0]  val1,
   input  logic [7:0]  val2,
   input  logic [7:0]  val3,
   output logic [1:0]  cnt,
   output logic [4:0]  col,
   output logic [4:0]  row,
   output logic        busy,
   output logic        out_valid,
   output logic [7:0]  pix_out,
   output logic [9:0]  out_addr,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [4:0] LAST = 5'(IMG_W - 3);

   state_t             state, state_nxt;
   logic [1:0]         drain_cnt;
   logic [71:0]        kernel_q;
   logic [9:0]         out_cnt;
   logic               s1_v;
   logic [1:0]         s1_k;
   logic signed [19:0] acc;
   logic               accept;
   logic               last_issue;

   logic signed [19:0] w0, w1, w2;
   logic signed [19:0] x1, x2, x3;
   logic signed [19:0] partial, acc_sum, shifted;
   logic [7:0]         clamped;

   assign accept     = (state == IDLE) && start;
   assign last_issue = (state == RUN) && (cnt == 2'd2) && (col == LAST) && (row == LAST);
   assign busy       = (state == RUN) || (state == DRAIN);
   assign done       = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_issue) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == 2'd1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Window position only advances while issuing; everywhere else it parks at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         col <= '0;
         row <= '0;
      end else if (state == RUN && !last_issue) begin
         if (cnt == 2'd2) begin
            cnt <= '0;
            if (col == LAST) begin
               col <= '0;
               row <= row + 5'd1;
            end else begin
               col <= col + 5'd1;
            end
         end else begin
            cnt <= cnt + 2'd1;
         end
      end else begin
         cnt <= '0;
         col <= '0;
         row <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kernel_q <= '0;
         s1_v     <= 1'b0;
         s1_k     <= '0;
      end else begin
         if (accept) kernel_q <= kernel;
         s1_v <= (state == RUN);
         s1_k <= cnt;
      end
   end

   // Column k of the kernel weights the three row values returned this cycle.
   always_comb begin
      w0      = 20'($signed(kernel_q[8*(0 + 32'(s1_k)) +: 8]));
      w1      = 20'($signed(kernel_q[8*(3 + 32'(s1_k)) +: 8]));
      w2      = 20'($signed(kernel_q[8*(6 + 32'(s1_k)) +: 8]));
      x1      = {12'd0, val1};
      x2      = {12'd0, val2};
      x3      = {12'd0, val3};
      partial = w0 * x1 + w1 * x2 + w2 * x3;
      acc_sum = ((s1_k == 2'd0) ? 20'sd0 : acc) + partial;
      shifted = acc_sum >>> SHIFT;
      if (shifted < 20'sd0)
         clamped = 8'd0;
      else if (shifted > 20'sd255)
         clamped = 8'd255;
      else
         clamped = shifted[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         pix_out   <= '0;
         out_addr  <= '0;
         out_cnt   <= '0;
      end else begin
         out_valid <= 1'b0;
         if (accept) out_cnt <= '0;
         if (s1_v) begin
            acc <= acc_sum;
            if (s1_k == 2'd2) begin
               pix_out   <= clamped;
               out_valid <= 1'b1;
               out_addr  <= out_cnt;
               out_cnt   <= out_cnt + 10'd1;
            end
         end
      end
   end

endmodule
